// File: rtl/sdram_user_pkg.sv
// Shared definitions for the SDRAM user-side responder: FSM states,
// default timing constants and a small helper for sizing counters.
package sdram_user_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_HOLD,
    ST_REFRESH
  } state_t;

  localparam int DEF_AW         = 4;
  localparam int DEF_INIT_CYC   = 200;
  localparam int DEF_REF_PERIOD = 780;
  localparam int DEF_REF_CYC    = 8;
  localparam int DEF_WR_LAT     = 2;
  localparam int DEF_RD_LAT     = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_user_mem.sv
// Single-port word RAM: synchronous write, registered (read-first) read.
module sdram_user_mem #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Write the addressed word when enabled and register the old contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sdram_user_responder.sv
// Behavioural stand-in for an SDRAM controller's user port: power-up busy
// period, periodic refresh, and fixed-latency write/read with a Done pulse.
module sdram_user_responder
  import sdram_user_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int INIT_CYC   = DEF_INIT_CYC,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int REF_CYC    = DEF_REF_CYC,
  parameter int WR_LAT     = DEF_WR_LAT,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WrEN_Sig,
  input  logic        RdEN_Sig,
  input  logic [21:0] BRC_Addr,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Done_Sig,
  output logic        Busy_Sig
);

  localparam int CNT_MAX = max_of(max_of(INIT_CYC, REF_CYC), max_of(WR_LAT, RD_LAT));
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(REF_PERIOD + 1);

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [AW-1:0]   r_addr, w_addr_next;
  logic            r_done, w_done_next;
  logic            r_busy;
  logic [15:0]     r_rdata;
  logic            w_rd_load;
  logic            w_mem_we;
  logic            w_ref_clr;
  logic            w_ref_start;
  logic            r_ref_en;
  logic            r_ref_pending;
  logic [RW-1:0]   r_ref_cnt;
  logic            w_ref_expire;
  logic [AW-1:0]   w_mem_addr;
  logic [15:0]     w_mem_rdata;
  logic            w_unused_addr;

  // Upper address bits are deliberately ignored so addresses alias modulo 2^AW.
  assign w_unused_addr = ^BRC_Addr[21:AW];

  // While idle the RAM looks at the live address so an accepted write lands
  // on the acceptance edge and a read's data is already in flight; otherwise
  // it keeps reading the captured address.
  assign w_mem_addr   = (r_state == ST_IDLE) ? BRC_Addr[AW-1:0] : r_addr;
  assign w_ref_expire = r_ref_en && (r_ref_cnt == RW'(REF_PERIOD - 1));

  sdram_user_mem #(
    .AW (AW),
    .DW (16)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (WrData),
    .o_rdata (w_mem_rdata)
  );

  // State register plus registered outputs (Busy follows the next state).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_done  <= w_done_next;
      r_busy  <= (w_state_next != ST_IDLE);
      if (w_rd_load) begin
        r_rdata <= w_mem_rdata;
      end
    end
  end

  // Next-state logic; one shared counter times INIT, latency and REFRESH.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_done_next  = 1'b0;
    w_rd_load    = 1'b0;
    w_mem_we     = 1'b0;
    w_ref_clr    = 1'b0;
    w_ref_start  = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == CW'(INIT_CYC - 1)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_ref_start  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (r_ref_pending) begin
          w_state_next = ST_REFRESH;
          w_cnt_next   = '0;
          w_ref_clr    = 1'b1;
        end else if (WrEN_Sig) begin
          w_state_next = ST_WRITE;
          w_cnt_next   = '0;
          w_addr_next  = BRC_Addr[AW-1:0];
          w_mem_we     = ~RST;
        end else if (RdEN_Sig) begin
          w_state_next = ST_READ;
          w_cnt_next   = '0;
          w_addr_next  = BRC_Addr[AW-1:0];
        end
      end
      ST_WRITE: begin
        if (r_cnt == CW'(WR_LAT - 1)) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_READ: begin
        if (r_cnt == CW'(RD_LAT - 1)) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
          w_rd_load    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        // The initiator still holds its enable this cycle; ignore it.
        w_state_next = ST_IDLE;
      end
      ST_REFRESH: begin
        if (r_cnt == CW'(REF_CYC - 1)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_INIT;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Free-running refresh timer started at INIT exit; an expiry wins over a
  // same-edge clear so no refresh request is ever lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ref_en      <= 1'b0;
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      if (w_ref_start) begin
        r_ref_en <= 1'b1;
      end
      if (r_ref_en) begin
        r_ref_cnt <= w_ref_expire ? '0 : r_ref_cnt + RW'(1);
      end
      if (w_ref_expire) begin
        r_ref_pending <= 1'b1;
      end else if (w_ref_clr) begin
        r_ref_pending <= 1'b0;
      end
    end
  end

  assign RdData   = r_rdata;
  assign Done_Sig = r_done;
  assign Busy_Sig = r_busy;

endmodule

// File: tb/tb_sdram_user_responder.sv
// Scoreboard bench for sdram_user_responder: a transaction-level model
// predicts acceptance edges (INIT, refresh, HOLD spacing) and read data.
module tb_sdram_user_responder;

  localparam int INIT_CYC   = 200;
  localparam int REF_PERIOD = 780;
  localparam int REF_CYC    = 8;
  localparam int WR_LAT     = 2;
  localparam int RD_LAT     = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WrEN_Sig = 1'b0;
  logic        RdEN_Sig = 1'b0;
  logic [21:0] BRC_Addr = '0;
  logic [15:0] WrData = '0;
  logic [15:0] RdData;
  logic        Done_Sig;
  logic        Busy_Sig;

  sdram_user_responder #(
    .AW         (4),
    .INIT_CYC   (INIT_CYC),
    .REF_PERIOD (REF_PERIOD),
    .REF_CYC    (REF_CYC),
    .WR_LAT     (WR_LAT),
    .RD_LAT     (RD_LAT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WrEN_Sig (WrEN_Sig),
    .RdEN_Sig (RdEN_Sig),
    .BRC_Addr (BRC_Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .Done_Sig (Done_Sig),
    .Busy_Sig (Busy_Sig)
  );

  always #5 CLK = ~CLK;

  // Edge counter: at a negedge, cyc is the index of the posedge just passed.
  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint      cyc;
    bit          rd;
    logic [21:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  longint      m_free_at;   // first edge at which a request can be accepted
  longint      m_next_exp;  // next refresh-timer expiry edge
  logic [15:0] m_mem [16];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset(input longint rel_edge);
    m_free_at  = rel_edge + INIT_CYC;
    m_next_exp = rel_edge + INIT_CYC - 1 + REF_PERIOD;
  endtask

  // Serve every refresh whose expiry precedes edge t.
  task automatic model_sync(input longint t);
    longint f;
    while (m_next_exp < t) begin
      f = (m_next_exp + 1 > m_free_at) ? m_next_exp + 1 : m_free_at;
      m_free_at  = f + REF_CYC + 1;
      m_next_exp = m_next_exp + REF_PERIOD;
    end
  endtask

  // Request visible from edge ti onward: refresh first, then acceptance.
  task automatic model_accept(input longint ti, input int lat, output longint acc);
    longint t;
    longint f;
    t = (ti > m_free_at) ? ti : m_free_at;
    while (m_next_exp < t) begin
      f = (m_next_exp + 1 > m_free_at) ? m_next_exp + 1 : m_free_at;
      m_free_at  = f + REF_CYC + 1;
      m_next_exp = m_next_exp + REF_PERIOD;
      t = (ti > m_free_at) ? ti : m_free_at;
    end
    acc = t;
    m_free_at = t + lat + 2;
  endtask

  // Monitor: every Done pulse is matched against the scoreboard head.
  bit prev_done = 1'b0;
  always @(negedge CLK) begin : mon
    exp_t e;
    if (Done_Sig) begin
      if (prev_done) begin
        checks++;
        errors++;
        $display("FAIL done_width at edge %0d: got 2+ cycles expected 1", cyc);
      end
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at edge %0d: got pulse expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("done_edge", cyc, e.cyc);
        if (e.rd) begin
          check("rd_data", RdData, e.data);
          $display("read  addr=%06h data=%04h done@%0d", e.addr, RdData, cyc);
        end else begin
          $display("write addr=%06h data=%04h done@%0d", e.addr, e.data, cyc);
        end
      end
    end
    prev_done = Done_Sig;
  end

  // Issue one request, hold it until Done, drop it one cycle late.
  task automatic do_txn(input bit wr, input bit rd, input logic [21:0] addr,
                        input logic [15:0] data, input int gap);
    longint acc;
    exp_t   e;
    int     lat;
    int     n;
    lat = wr ? WR_LAT : RD_LAT;
    WrEN_Sig = wr;
    RdEN_Sig = rd;
    BRC_Addr = addr;
    WrData   = data;
    model_accept(cyc + 1, lat, acc);
    if (wr) m_mem[addr[3:0]] = data;
    e.cyc  = acc + lat;
    e.rd   = !wr;
    e.addr = addr;
    e.data = m_mem[addr[3:0]];
    sb_q.push_back(e);
    n = 0;
    while (!Done_Sig && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (!Done_Sig) begin
      checks++;
      errors++;
      $display("FAIL done_timeout at edge %0d: got no Done expected at edge %0d", cyc, e.cyc);
      WrEN_Sig = 1'b0;
      RdEN_Sig = 1'b0;
      sb_q.delete();
      return;
    end
    @(negedge CLK);
    WrEN_Sig = 1'b0;
    RdEN_Sig = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  initial begin : watchdog
    repeat (40000) @(posedge CLK);
    $display("FAIL watchdog at edge %0d: got no finish expected finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    longint rel;
    longint x_edge;
    longint acc;
    int     bad;
    int     n;
    bit     wr;
    bit     rd;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", Busy_Sig, 1);
    check("rst_done", Done_Sig, 0);
    check("rst_rddata", RdData, 0);

    // Power-up: busy for exactly INIT_CYC cycles after release
    RST = 1'b0;
    rel = cyc + 1;
    model_reset(rel);
    x_edge = rel + INIT_CYC - 1;
    bad = 0;
    while (cyc < x_edge + 1) begin
      @(negedge CLK);
      if (Busy_Sig != (cyc < x_edge)) bad++;
      if (cyc == x_edge - 1) check("init_busy_last", Busy_Sig, 1);
      if (cyc == x_edge) check("init_busy_clear", Busy_Sig, 0);
    end
    check("init_busy_profile_errs", bad, 0);

    // Write then read word 0
    do_txn(1'b1, 1'b0, 22'd0, 16'h8421, 1);
    do_txn(1'b0, 1'b1, 22'd0, 16'h0000, 2);

    // Fill words 1..15 with their address, then read them back
    for (int a = 1; a < 16; a++) do_txn(1'b1, 1'b0, 22'(a), 16'(a), $urandom_range(0, 2));
    for (int a = 1; a < 16; a++) do_txn(1'b0, 1'b1, 22'(a), 16'h0000, $urandom_range(0, 2));

    // Both enables high: the write wins
    do_txn(1'b1, 1'b1, 22'd3, 16'hA5A5, 1);
    do_txn(1'b0, 1'b1, 22'd3, 16'h0000, 1);

    // Address aliasing above AW bits
    do_txn(1'b1, 1'b0, 22'h000010, 16'h1357, 0);
    do_txn(1'b0, 1'b1, 22'h000000, 16'h0000, 0);
    do_txn(1'b1, 1'b0, 22'h3FFFF5, 16'h2468, 1);
    do_txn(1'b0, 1'b1, 22'h000005, 16'h0000, 1);

    // Randomized mix
    repeat (20) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(wr, rd, 22'($urandom), 16'($urandom), $urandom_range(0, 3));
    end

    // Refresh expiry during a read, then a write that has to wait for it
    model_sync(cyc + 1);
    while (m_next_exp < cyc + 3) begin
      repeat (4) @(negedge CLK);
      model_sync(cyc + 1);
    end
    while (cyc < m_next_exp - 2) @(negedge CLK);
    do_txn(1'b0, 1'b1, 22'd7, 16'h0000, 0);
    do_txn(1'b1, 1'b0, 22'd9, 16'hBEEF, 1);
    do_txn(1'b0, 1'b1, 22'd9, 16'h0000, 1);

    // Reset one cycle after a read is accepted: aborted, no Done
    RdEN_Sig = 1'b1;
    BRC_Addr = 22'd2;
    model_accept(cyc + 1, RD_LAT, acc);
    n = 0;
    while (cyc < acc && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    RST = 1'b1;
    @(negedge CLK);
    RdEN_Sig = 1'b0;
    check("abort_done", Done_Sig, 0);
    check("abort_rddata", RdData, 0);
    check("abort_busy", Busy_Sig, 1);
    RST = 1'b0;
    rel = cyc + 1;
    model_reset(rel);
    x_edge = rel + INIT_CYC - 1;
    while (cyc < x_edge - 1) @(negedge CLK);
    check("reinit_busy_last", Busy_Sig, 1);
    @(negedge CLK);
    check("reinit_busy_clear", Busy_Sig, 0);
    check("reinit_no_rddata", RdData, 0);

    // Memory survives reset
    do_txn(1'b0, 1'b1, 22'd2, 16'h0000, 0);
    do_txn(1'b0, 1'b1, 22'd9, 16'h0000, 0);
    do_txn(1'b0, 1'b1, 22'd0, 16'h0000, 2);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
